// File: rtl/calc_engine.sv
// calc_engine: keypad calculator engine with signed decimal entry, ADD/SUB/MUL and serial restoring DIV
module calc_engine #(
  parameter int W     = 11,
  parameter int NDIG  = 3,
  parameter int KEY_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  input  logic [KEY_W-1:0] key_code,
  output logic             key_ready,
  output logic             busy,
  output logic [W-1:0]     result,
  output logic             result_valid,
  output logic             err
);
  localparam int MW   = $clog2(10 ** NDIG);
  localparam int MAGW = MW > W ? MW : W;
  localparam int CW   = $clog2(NDIG + 1);
  localparam int XW   = 2 * W + 1;
  localparam int DCW  = $clog2(W);
  localparam logic [MAGW-1:0] LIM = MAGW'(1) << (W - 1);
  localparam logic [2:0] S_SIGN1 = 3'd0;
  localparam logic [2:0] S_DIG1  = 3'd1;
  localparam logic [2:0] S_OP    = 3'd2;
  localparam logic [2:0] S_SIGN2 = 3'd3;
  localparam logic [2:0] S_DIG2  = 3'd4;
  localparam logic [2:0] S_EXEC  = 3'd5;
  localparam logic [2:0] S_DIV   = 3'd6;
  localparam logic [1:0] OP_ADD  = 2'd0;
  localparam logic [1:0] OP_SUB  = 2'd1;
  localparam logic [1:0] OP_DIV  = 2'd3;
  logic [2:0] state;
  logic [1:0] op;
  logic neg, ovf, dneg;
  logic [MAGW-1:0] mag, mag_nx;
  logic [CW-1:0] cnt;
  logic [W-1:0] a, b, dq, dvs, rem;
  logic [DCW-1:0] dcnt;
  logic [3:0] k;
  logic kv, is_dig, is_ent, is_clr, is_pm, is_op;
  logic [W-1:0] op_val, abs_a, abs_b, rem_nx, dq_nx, quo;
  logic op_ovf, fits, q_ovf;
  logic [W:0] sh, diff;
  logic signed [XW-1:0] ea, eb, full;

  assign key_ready = !(state == S_EXEC || state == S_DIV);
  assign busy = !key_ready;

  // key decode, operand formation, wide ADD/SUB/MUL and one restoring-divide step
  always_comb begin
    k = key_code[3:0];
    kv = key_valid && key_code < KEY_W'(16);
    is_dig = kv && k < 4'd10;
    is_pm = kv && (k == 4'd10 || k == 4'd11);
    is_op = kv && k >= 4'd10 && k <= 4'd13;
    is_ent = kv && k == 4'd14;
    is_clr = kv && k == 4'd15;
    mag_nx = mag * MAGW'(10) + MAGW'(k);
    op_val = neg ? W'(0) - mag[W-1:0] : mag[W-1:0];
    op_ovf = mag > (neg ? LIM : LIM - MAGW'(1));
    abs_a = a[W-1] ? W'(0) - a : a;
    abs_b = b[W-1] ? W'(0) - b : b;
    ea = {{(W+1){a[W-1]}}, a};
    eb = {{(W+1){b[W-1]}}, b};
    full = op == OP_ADD ? ea + eb : op == OP_SUB ? ea - eb : ea * eb;
    fits = &full[XW-1:W-1] || ~|full[XW-1:W-1];
    sh = {rem, dq[W-1]};
    diff = sh - {1'b0, dvs};
    rem_nx = diff[W] ? sh[W-1:0] : diff[W-1:0];
    dq_nx = {dq[W-2:0], ~diff[W]};
    quo = dneg ? W'(0) - dq_nx : dq_nx;
    q_ovf = !dneg && dq_nx[W-1];
  end

  // entry FSM, execute step and divider; clear aborts anything, results update only with result_valid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_SIGN1;
      op <= OP_ADD;
      neg <= 1'b0;
      ovf <= 1'b0;
      mag <= '0;
      cnt <= '0;
      a <= '0;
      b <= '0;
      dq <= '0;
      dvs <= '0;
      rem <= '0;
      dneg <= 1'b0;
      dcnt <= '0;
      result <= '0;
      result_valid <= 1'b0;
      err <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (is_clr) begin
        state <= S_SIGN1;
        op <= OP_ADD;
        neg <= 1'b0;
        ovf <= 1'b0;
        mag <= '0;
        cnt <= '0;
        a <= '0;
        b <= '0;
      end else begin
        case (state)
          S_SIGN1, S_SIGN2: begin
            if (is_pm) begin
              neg <= k[0];
              state <= state + 3'd1;
            end else if (is_dig) begin
              neg <= 1'b0;
              mag <= MAGW'(k);
              cnt <= CW'(1);
              state <= state + 3'd1;
            end
          end
          S_DIG1, S_DIG2: begin
            if (is_dig && int'(cnt) < NDIG) begin
              mag <= mag_nx;
              cnt <= cnt + CW'(1);
            end else if (is_ent) begin
              if (state == S_DIG1) a <= op_val;
              else b <= op_val;
              ovf <= ovf | op_ovf;
              neg <= 1'b0;
              mag <= '0;
              cnt <= '0;
              state <= state + 3'd1;
            end
          end
          S_OP: begin
            if (is_op) op <= 2'(k - 4'd10);
            else if (is_ent) state <= S_SIGN2;
          end
          S_EXEC: begin
            if (op == OP_DIV && b != '0) begin
              dq <= abs_a;
              dvs <= abs_b;
              rem <= '0;
              dneg <= a[W-1] ^ b[W-1];
              dcnt <= '0;
              state <= S_DIV;
            end else begin
              result <= op == OP_DIV ? '0 : full[W-1:0];
              err <= ovf || op == OP_DIV || !fits;
              result_valid <= 1'b1;
              state <= S_SIGN1;
              op <= OP_ADD;
              ovf <= 1'b0;
              a <= '0;
              b <= '0;
            end
          end
          S_DIV: begin
            dq <= dq_nx;
            rem <= rem_nx;
            dcnt <= dcnt + DCW'(1);
            if (dcnt == DCW'(W - 1)) begin
              result <= quo;
              err <= ovf || q_ovf;
              result_valid <= 1'b1;
              state <= S_SIGN1;
              op <= OP_ADD;
              ovf <= 1'b0;
              a <= '0;
              b <= '0;
            end
          end
          default: state <= S_SIGN1;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_calc_engine.sv
// tb_calc_engine: directed and randomized expressions checked against an arithmetic reference model
module tb_calc_engine;
  localparam int W = 11;
  localparam int NDIG = 3;
  localparam int KEY_W = 11;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic key_valid = 1'b0;
  logic [KEY_W-1:0] key_code = '0;
  logic key_ready, busy, result_valid, err;
  logic [W-1:0] result;
  int checks = 0;
  int errors = 0;
  int kq[$];

  calc_engine #(.W(W), .NDIG(NDIG), .KEY_W(KEY_W)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready), .busy(busy), .result(result),
    .result_valid(result_valid), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic key(input int c);
    key_valid = 1'b1;
    key_code = KEY_W'(c);
    @(posedge clk);
    #1;
    key_valid = 1'b0;
  endtask

  task automatic send_body(input bit gaps);
    for (int i = 0; i < kq.size() - 1; i++) begin
      key(kq[i]);
      if (gaps) idle(int'($urandom_range(0, 2)));
    end
  endtask

  task automatic finish_expr(input string tag, input int lat, input longint r, input bit e);
    int n;
    key(kq[kq.size() - 1]);
    check({tag, "_busy"}, longint'(busy), 1);
    check({tag, "_key_ready_lo"}, longint'(key_ready), 0);
    n = 1;
    while (!result_valid && n < 64) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_latency"}, n, lat);
    check({tag, "_result"}, longint'(result), r & ((longint'(1) << W) - 1));
    check({tag, "_err"}, longint'(err), longint'(e));
    @(posedge clk);
    #1;
    check({tag, "_pulse_end"}, longint'(result_valid), 0);
    check({tag, "_key_ready_hi"}, longint'(key_ready), 1);
  endtask

  function automatic void model(input longint x, input longint y, input int op, input bit ovf,
                                output longint r, output bit e, output int lat);
    longint hi = (longint'(1) << (W - 1)) - 1;
    longint lo = -(longint'(1) << (W - 1));
    e = ovf;
    lat = 2;
    if (op == 3) begin
      if (y == 0) begin
        r = 0;
        e = 1'b1;
      end else begin
        r = x / y;
        lat = W + 2;
      end
    end else r = op == 0 ? x + y : op == 1 ? x - y : x * y;
    if (r < lo || r > hi) e = 1'b1;
  endfunction

  task automatic gen_operand(output longint v, output bit ov);
    int mode = int'($urandom_range(0, 2));
    int nd = int'($urandom_range(mode == 2 ? 1 : 0, 5));
    int junk[4] = '{14, 12, 13, 16};
    longint m = 0;
    int j;
    if ($urandom_range(0, 3) == 0) begin
      j = junk[$urandom_range(0, 3)];
      kq.push_back(j == 16 ? int'($urandom_range(16, (1 << KEY_W) - 1)) : j);
    end
    if (mode < 2) kq.push_back(10 + mode);
    for (int i = 0; i < nd; i++) begin
      int d = int'($urandom_range(0, 9));
      kq.push_back(d);
      if (i < NDIG) m = m * 10 + d;
      if ($urandom_range(0, 5) == 0) kq.push_back(int'($urandom_range(16, (1 << KEY_W) - 1)));
    end
    kq.push_back(14);
    v = mode == 1 ? -m : m;
    ov = m > (mode == 1 ? (longint'(1) << (W - 1)) : (longint'(1) << (W - 1)) - 1);
  endtask

  initial begin
    int nrv;
    longint x, y, r;
    bit ox, oy, e;
    int op, lat, nops;
    #12;
    check("rst_result", longint'(result), 0);
    check("rst_valid", longint'(result_valid), 0);
    check("rst_err", longint'(err), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_key_ready", longint'(key_ready), 1);
    @(negedge clk);
    rst = 1'b1;
    idle(1);
    kq = '{1, 2, 14, 10, 14, 3, 4, 14};
    send_body(1'b0);
    finish_expr("t1_add", 2, 46, 1'b0);
    kq = '{11, 5, 14, 12, 14, 7, 14};
    send_body(1'b1);
    finish_expr("t2_mul", 2, -35, 1'b0);
    kq = '{1, 0, 0, 14, 13, 14, 11, 7, 14};
    send_body(1'b0);
    finish_expr("t3_div", W + 2, -14, 1'b0);
    kq = '{7, 14, 13, 14, 0, 14};
    send_body(1'b0);
    finish_expr("t4_div0", 2, 0, 1'b1);
    kq = '{9, 9, 9, 14, 12, 14, 3, 14};
    send_body(1'b0);
    finish_expr("t4_mulovf", 2, 2997, 1'b1);
    kq = '{4, 5, 6, 7, 14, 10, 14, 1, 14};
    send_body(1'b0);
    finish_expr("t5_ndig", 2, 457, 1'b0);
    kq = '{1, 0, 0, 14, 13, 14, 7, 14};
    send_body(1'b0);
    key(14);
    idle(3);
    check("t5_div_busy", longint'(busy), 1);
    key(5);
    key(15);
    check("t5_clr_ready", longint'(key_ready), 1);
    check("t5_clr_busy", longint'(busy), 0);
    nrv = 0;
    repeat (W + 4) begin
      @(posedge clk);
      #1;
      if (result_valid) nrv++;
    end
    check("t5_clr_no_valid", nrv, 0);
    check("t5_clr_hold", longint'(result), 457);
    kq = '{2, 14, 10, 14, 2, 14};
    send_body(1'b1);
    key(14);
    key(9);
    check("exec_edge_valid", longint'(result_valid), 1);
    check("exec_edge_result", longint'(result), 4);
    kq = '{3, 14, 11, 14, 1, 14};
    send_body(1'b0);
    finish_expr("exec_edge_drop", 2, 2, 1'b0);
    kq = '{1, 0, 0, 14, 13, 14, 7, 14};
    send_body(1'b0);
    key(14);
    idle(3);
    #2;
    rst = 1'b0;
    #1;
    check("t6_result", longint'(result), 0);
    check("t6_valid", longint'(result_valid), 0);
    check("t6_err", longint'(err), 0);
    check("t6_busy", longint'(busy), 0);
    check("t6_key_ready", longint'(key_ready), 1);
    @(negedge clk);
    rst = 1'b1;
    idle(1);
    kq = '{5, 14, 12, 14, 5, 14};
    send_body(1'b0);
    finish_expr("t6_after", 2, 25, 1'b0);
    for (int t = 0; t < 40; t++) begin
      kq = {};
      gen_operand(x, ox);
      nops = int'($urandom_range(1, 3));
      op = 0;
      for (int i = 0; i < nops; i++) begin
        op = int'($urandom_range(0, 3));
        kq.push_back(10 + op);
        if ($urandom_range(0, 4) == 0) kq.push_back(int'($urandom_range(16, (1 << KEY_W) - 1)));
      end
      kq.push_back(14);
      gen_operand(y, oy);
      model(x, y, op, ox | oy, r, e, lat);
      send_body(1'b1);
      finish_expr($sformatf("rnd%0d", t), lat, r, e);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
